macc_acc_cell: RTL and testbench

//  Pipelined multiply-accumulate cell for the MPU systolic array. Holds NREGS accumulator tiles.

---
 rtl/mpu_macc_pkg.sv | 57 +++++
 rtl/macc_lane_mul.sv | 78 +++++++
 rtl/macc_acc_cell.sv | 120 ++++++++++++
 tb/tb_macc_acc_cell.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_macc_pkg.sv
// Shared types and lane arithmetic helpers for the MPU multiply-accumulate cell.
// Lane width is selected per op; all helpers work on a 64-bit lane container.
package mpu_macc_pkg;

   // Wide enough for any supported tile count; the top zero-extends its index into it.
   localparam int ADDR_W_MAX = 8;

   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2,
      SEW64 = 2'd3
   } sew_e;

   typedef struct packed {
      logic [ADDR_W_MAX-1:0] addr;
      sew_e                  sew;
      logic                  acc;
      logic                  sat;
   } macc_op_t;

   function automatic int lane_w(input sew_e sew);
      return 8 << int'(sew);
   endfunction

   // Clamp a wide signed sum into the signed range of one lane; result sits in the low lane bits.
   function automatic logic [63:0] sat_clamp(input logic signed [129:0] sum, input sew_e sew);
      logic signed [129:0] hi;
      logic signed [129:0] lo;
      hi = (130'sd1 <<< (lane_w(sew) - 1)) - 130'sd1;
      lo = -(130'sd1 <<< (lane_w(sew) - 1));
      if (sum > hi) return hi[63:0];
      if (sum < lo) return lo[63:0];
      return sum[63:0];
   endfunction

   // One lane of c + p: c holds the lane in its low w bits, p the 2w-bit product.
   function automatic logic [63:0] lane_calc(input logic [63:0]  c,
                                             input logic [127:0] p,
                                             input sew_e         sew,
                                             input logic         sat);
      logic signed [129:0] cs;
      logic signed [129:0] ps;
      logic [63:0]         wrap;
      cs = '0;
      ps = '0;
      unique case (sew)
         SEW8:  begin cs = 130'($signed(c[7:0]));  ps = 130'($signed(p[15:0]));  end
         SEW16: begin cs = 130'($signed(c[15:0])); ps = 130'($signed(p[31:0]));  end
         SEW32: begin cs = 130'($signed(c[31:0])); ps = 130'($signed(p[63:0]));  end
         SEW64: begin cs = 130'($signed(c));       ps = 130'($signed(p));        end
      endcase
      wrap = c + p[63:0];
      return sat ? sat_clamp(cs + ps, sew) : wrap;
   endfunction

endpackage

// File: rtl/macc_lane_mul.sv
// Packed SIMD multiplier: per-lane 2w-bit products for the op's lane width, delayed by
// MUL_STAGES-1 register stages together with the op descriptor and its valid.
module macc_lane_mul
   import mpu_macc_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int MUL_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  macc_op_t          in_op,
   input  logic [XLEN-1:0]   ai,
   input  logic [XLEN-1:0]   bj,
   output logic              out_valid,
   output macc_op_t          out_op,
   output logic [2*XLEN-1:0] out_prod,
   output logic              busy
);

   localparam int NS = MUL_STAGES - 1;

   logic [3:0][2*XLEN-1:0] prod_by_sew;
   logic [2*XLEN-1:0]      prod_in;

   // Operands are sign-extended only for saturating ops; the low 2w bits of the
   // 2w x 2w product are then the exact signed or unsigned lane product.
   for (genvar s = 0; s < 4; s++) begin : g_sew
      localparam int W = 8 << s;
      for (genvar l = 0; l < XLEN / W; l++) begin : g_lane
         logic [2*W-1:0] a_x;
         logic [2*W-1:0] b_x;
         assign a_x = {{W{ai[l*W+W-1] & in_op.sat}}, ai[l*W +: W]};
         assign b_x = {{W{bj[l*W+W-1] & in_op.sat}}, bj[l*W +: W]};
         assign prod_by_sew[s][l*2*W +: 2*W] = a_x * b_x;
      end
   end

   assign prod_in = prod_by_sew[in_op.sew];

   if (NS == 0) begin : g_comb
      assign out_valid = in_valid;
      assign out_op    = in_op;
      assign out_prod  = prod_in;
      assign busy      = 1'b0;
   end else begin : g_pipe
      logic [NS-1:0]     v_q;
      macc_op_t          op_q [NS];
      logic [2*XLEN-1:0] p_q  [NS];

      // NOTE: state registers use non-blocking assignments so every stage samples the
      // pre-edge value of its predecessor regardless of statement order.
      always_ff @(posedge clk) begin
         if (reset) begin
            v_q <= '0;
         end else begin
            v_q[0] <= in_valid;
            for (int i = 1; i < NS; i++) v_q[i] <= v_q[i-1];
         end
      end

      // NOTE: the op/product stages carry no reset; the valid bits alone qualify them.
      always_ff @(posedge clk) begin
         op_q[0] <= in_op;
         p_q[0]  <= prod_in;
         for (int i = 1; i < NS; i++) begin
            op_q[i] <= op_q[i-1];
            p_q[i]  <= p_q[i-1];
         end
      end

      assign out_valid = v_q[NS-1];
      assign out_op    = op_q[NS-1];
      assign out_prod  = p_q[NS-1];
      assign busy      = |v_q;
   end

endmodule

// File: rtl/macc_acc_cell.sv
// Pipelined SIMD multiply-accumulate cell holding NREGS accumulator tiles, with a load
// port, a registered store port and a sticky load/writeback collision flag.
module macc_acc_cell
   import mpu_macc_pkg::*;
#(
   parameter int NREGS      = 4,
   parameter int XLEN       = 64,
   parameter int MUL_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ab_valid,
   input  logic [$clog2(NREGS)-1:0] ab_addr,
   input  logic [1:0]               ab_sew,
   input  logic                     ab_acc,
   input  logic                     ab_sat,
   input  logic [XLEN-1:0]          ai,
   input  logic [XLEN-1:0]          bj,
   input  logic                     ci_valid,
   input  logic [$clog2(NREGS)-1:0] cld_addr,
   input  logic [XLEN-1:0]          ci,
   input  logic                     cs_valid,
   input  logic [$clog2(NREGS)-1:0] cst_addr,
   output logic [XLEN-1:0]          co,
   output logic                     co_valid,
   output logic                     busy,
   output logic                     err
);

   localparam int AW = $clog2(NREGS);

   macc_op_t          issue_op;
   logic              wb_valid;
   macc_op_t          wb_op;
   logic [2*XLEN-1:0] wb_prod;
   logic [XLEN-1:0]   c_src;
   logic [XLEN-1:0]   wb_val;
   logic              collision;
   logic [XLEN-1:0]   tile      [NREGS];
   logic [XLEN-1:0]   tile_next [NREGS];

   assign issue_op = '{addr: ADDR_W_MAX'(ab_addr), sew: sew_e'(ab_sew), acc: ab_acc, sat: ab_sat};

   macc_lane_mul #(
      .XLEN       (XLEN),
      .MUL_STAGES (MUL_STAGES)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (ab_valid),
      .in_op     (issue_op),
      .ai        (ai),
      .bj        (bj),
      .out_valid (wb_valid),
      .out_op    (wb_op),
      .out_prod  (wb_prod),
      .busy      (busy)
   );

   // Accumulator is read here, in the writeback stage, so back-to-back ops chain.
   always_comb begin
      c_src = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (wb_op.acc && wb_op.addr == ADDR_W_MAX'(i)) c_src = tile[i];
      end
   end

   always_comb begin
      logic [63:0] lane_r;
      lane_r = '0;
      wb_val = '0;
      unique case (wb_op.sew)
         SEW8: for (int l = 0; l < XLEN / 8; l++) begin
            lane_r = lane_calc(64'(c_src[l*8 +: 8]), 128'(wb_prod[l*16 +: 16]), SEW8, wb_op.sat);
            wb_val[l*8 +: 8] = lane_r[7:0];
         end
         SEW16: for (int l = 0; l < XLEN / 16; l++) begin
            lane_r = lane_calc(64'(c_src[l*16 +: 16]), 128'(wb_prod[l*32 +: 32]), SEW16, wb_op.sat);
            wb_val[l*16 +: 16] = lane_r[15:0];
         end
         SEW32: for (int l = 0; l < XLEN / 32; l++) begin
            lane_r = lane_calc(64'(c_src[l*32 +: 32]), 128'(wb_prod[l*64 +: 64]), SEW32, wb_op.sat);
            wb_val[l*32 +: 32] = lane_r[31:0];
         end
         SEW64: for (int l = 0; l < XLEN / 64; l++) begin
            lane_r = lane_calc(c_src[l*64 +: 64], wb_prod[l*128 +: 128], SEW64, wb_op.sat);
            wb_val[l*64 +: 64] = lane_r;
         end
      endcase
   end

   assign collision = ci_valid && wb_valid && (ADDR_W_MAX'(cld_addr) == wb_op.addr);

   // NOTE: every path through this block starts from the held tile value, so no latch
   // can be inferred even when neither the load nor the writeback targets a tile.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         tile_next[i] = tile[i];
         if (wb_valid && wb_op.addr == ADDR_W_MAX'(i)) tile_next[i] = wb_val;
         if (ci_valid && cld_addr == AW'(i))           tile_next[i] = ci;
      end
   end

   // NOTE: the tiles are a small flop array, so they are cleared on reset like any
   // other state; a RAM-based tile store would need an explicit clear sequence instead.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) tile[i] <= '0;
         co       <= '0;
         co_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) tile[i] <= tile_next[i];
         err      <= err | collision;
         co_valid <= cs_valid;
         if (cs_valid) co <= tile_next[cst_addr];
      end
   end

endmodule

// File: tb/tb_macc_acc_cell.sv
// Self-checking bench for macc_acc_cell: directed scenarios plus randomized traffic
// compared every cycle against a queue-based per-lane arithmetic model.
module tb_macc_acc_cell;

   localparam int NREGS = 4;
   localparam int XLEN  = 64;
   localparam int MS    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ab_valid;
   logic [1:0]  ab_addr;
   logic [1:0]  ab_sew;
   logic        ab_acc;
   logic        ab_sat;
   logic [63:0] ai;
   logic [63:0] bj;
   logic        ci_valid;
   logic [1:0]  cld_addr;
   logic [63:0] ci;
   logic        cs_valid;
   logic [1:0]  cst_addr;
   logic [63:0] co;
   logic        co_valid;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   macc_acc_cell #(
      .NREGS      (NREGS),
      .XLEN       (XLEN),
      .MUL_STAGES (MS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ab_valid (ab_valid),
      .ab_addr  (ab_addr),
      .ab_sew   (ab_sew),
      .ab_acc   (ab_acc),
      .ab_sat   (ab_sat),
      .ai       (ai),
      .bj       (bj),
      .ci_valid (ci_valid),
      .cld_addr (cld_addr),
      .ci       (ci),
      .cs_valid (cs_valid),
      .cst_addr (cst_addr),
      .co       (co),
      .co_valid (co_valid),
      .busy     (busy),
      .err      (err)
   );

   typedef struct {
      logic [1:0]  addr;
      logic [1:0]  sew;
      logic        acc;
      logic        sat;
      logic [63:0] a;
      logic [63:0] b;
      int          due;
   } op_t;

   op_t         pend[$];
   logic [63:0] m_tile [NREGS];
   logic [63:0] m_co;
   logic        m_cov;
   logic        m_err;
   int          edge_n;
   int          n_checks;
   int          n_fail;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic signed [129:0] sext(input logic [63:0] v, input int w);
      logic [63:0]         t;
      logic signed [129:0] s;
      t = v << (64 - w);
      s = $signed(t);
      return s >>> (64 - w);
   endfunction

   // Reference: per-lane result built from plain integer arithmetic, one lane at a time.
   function automatic logic [63:0] ref_mac(input logic [63:0] c, input logic [63:0] a,
                                           input logic [63:0] b, input logic [1:0] sew,
                                           input logic acc, input logic sat);
      int                  w;
      logic [63:0]         mask, av, bv, cv, lane, r;
      logic signed [129:0] sum, hi, lo;
      w    = 8 << sew;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      r    = '0;
      for (int l = 0; l < 64 / w; l++) begin
         av = (a >> (l * w)) & mask;
         bv = (b >> (l * w)) & mask;
         cv = acc ? ((c >> (l * w)) & mask) : 64'd0;
         if (!sat) begin
            lane = (cv + av * bv) & mask;
         end else begin
            sum = sext(cv, w) + sext(av, w) * sext(bv, w);
            hi  = (130'sd1 <<< (w - 1)) - 130'sd1;
            lo  = -(130'sd1 <<< (w - 1));
            if (sum > hi) sum = hi;
            else if (sum < lo) sum = lo;
            lane = sum[63:0] & mask;
         end
         r = r | (lane << (l * w));
      end
      return r;
   endfunction

   // Advance one clock edge: update the model from the inputs present, then compare.
   task automatic step();
      op_t         wb;
      bit          has_wb;
      logic [63:0] nt [NREGS];
      @(posedge clk);
      edge_n++;
      if (reset) begin
         pend.delete();
         for (int i = 0; i < NREGS; i++) m_tile[i] = '0;
         m_co  = '0;
         m_cov = 1'b0;
         m_err = 1'b0;
      end else begin
         if (ab_valid)
            pend.push_back(op_t'{addr: ab_addr, sew: ab_sew, acc: ab_acc, sat: ab_sat,
                                 a: ai, b: bj, due: edge_n + MS - 1});
         has_wb = 1'b0;
         if (pend.size() > 0 && pend[0].due == edge_n) begin
            wb     = pend.pop_front();
            has_wb = 1'b1;
         end
         nt = m_tile;
         if (has_wb) nt[wb.addr] = ref_mac(m_tile[wb.addr], wb.a, wb.b, wb.sew, wb.acc, wb.sat);
         if (ci_valid) nt[cld_addr] = ci;
         if (has_wb && ci_valid && cld_addr == wb.addr) m_err = 1'b1;
         m_tile = nt;
         if (cs_valid) m_co = nt[cst_addr];
         m_cov = cs_valid;
      end
      #1;
      check("co", co, m_co);
      check("co_valid", 64'(co_valid), 64'(m_cov));
      check("busy", 64'(busy), 64'(pend.size() != 0));
      check("err", 64'(err), 64'(m_err));
   endtask

   task automatic idle();
      reset    = 1'b0;
      ab_valid = 1'b0;
      ci_valid = 1'b0;
      cs_valid = 1'b0;
   endtask

   task automatic set_op(input logic [1:0] addr, input logic [1:0] sew, input logic acc,
                         input logic sat, input logic [63:0] a, input logic [63:0] b);
      ab_valid = 1'b1;
      ab_addr  = addr;
      ab_sew   = sew;
      ab_acc   = acc;
      ab_sat   = sat;
      ai       = a;
      bj       = b;
   endtask

   task automatic set_load(input logic [1:0] addr, input logic [63:0] d);
      ci_valid = 1'b1;
      cld_addr = addr;
      ci       = d;
   endtask

   task automatic set_store(input logic [1:0] addr);
      cs_valid = 1'b1;
      cst_addr = addr;
   endtask

   function automatic logic [63:0] rand_word();
      logic [63:0] edge_vals [8];
      edge_vals = '{64'h7F7F7F7F7F7F7F7F, 64'h8080808080808080, 64'hFFFFFFFFFFFFFFFF,
                    64'h7FFF7FFF7FFF7FFF, 64'h8000800080008000, 64'h7FFFFFFF80000000,
                    64'h7FFFFFFFFFFFFFFF, 64'h8000000000000000};
      if ($urandom_range(0, 2) == 0) return edge_vals[$urandom_range(0, 7)];
      return {$urandom, $urandom};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      edge_n   = 0;
      ab_addr  = '0; ab_sew = '0; ab_acc = 1'b0; ab_sat = 1'b0; ai = '0; bj = '0;
      cld_addr = '0; ci = '0; cst_addr = '0;
      idle();
      reset = 1'b1;
      step();
      step();
      check("reset_co", co, 64'd0);
      check("reset_busy", 64'(busy), 64'd0);

      // SEW8 wrap accumulate onto a loaded tile
      idle(); set_load(2'd0, {8{8'h10}}); step();
      idle(); set_op(2'd0, 2'd0, 1'b1, 1'b0, {8{8'h03}}, {8{8'h05}}); step();
      idle(); repeat (MS - 1) step();
      set_store(2'd0); step();
      check("sew8_wrap", co, {8{8'h1F}});

      // SEW16 saturating vs wrapping on zeroed tiles
      idle(); set_load(2'd1, 64'd0); step();
      idle(); set_load(2'd2, 64'd0); step();
      idle(); set_op(2'd1, 2'd1, 1'b1, 1'b1, {4{16'h7FFF}}, {4{16'h0002}}); step();
      idle(); set_op(2'd2, 2'd1, 1'b1, 1'b0, {4{16'h7FFF}}, {4{16'h0002}}); step();
      idle(); repeat (MS) step();
      set_store(2'd1); step();
      check("sew16_sat", co, {4{16'h7FFF}});
      idle(); set_store(2'd2); step();
      check("sew16_wrap", co, {4{16'hFFFE}});

      // Four back-to-back ops chaining into tile1
      idle(); set_load(2'd1, 64'd0); step();
      for (int k = 0; k < 4; k++) begin
         idle(); set_op(2'd1, 2'd3, 1'b1, 1'b0, 64'd1, 64'd1); step();
      end
      idle();
      for (int k = 1; k < MS; k++) begin
         check("chain_busy_hi", 64'(busy), 64'd1);
         step();
      end
      check("chain_busy_lo", 64'(busy), 64'd0);
      set_store(2'd1); step();
      check("chain_sum", co, 64'd4);

      // Load and writeback on different tiles: both land, no error
      idle(); set_op(2'd3, 2'd3, 1'b0, 1'b0, 64'd3, 64'd5); step();
      idle(); repeat (MS - 2) step();
      set_load(2'd2, {8{8'hAA}}); step();
      idle(); set_store(2'd3); step();
      check("nocoll_op_tile", co, 64'd15);
      check("nocoll_err", 64'(err), 64'd0);
      idle(); set_store(2'd2); step();
      check("nocoll_ld_tile", co, {8{8'hAA}});

      // Load and writeback on the same tile: load wins, err sticks
      idle(); set_op(2'd2, 2'd3, 1'b0, 1'b0, 64'd3, 64'd5); step();
      idle(); repeat (MS - 2) step();
      set_load(2'd2, {8{8'hAA}}); step();
      idle(); step();
      check("coll_err", 64'(err), 64'd1);
      set_store(2'd2); step();
      check("coll_tile", co, {8{8'hAA}});

      // Store in the writeback cycle sees the freshly written value
      idle(); set_op(2'd0, 2'd2, 1'b1, 1'b0, {2{32'h2}}, {2{32'h10}}); step();
      idle(); repeat (MS - 2) step();
      set_store(2'd0); step();
      check("bypass_co", co, 64'h1F1F1F3F1F1F1F3F);
      check("bypass_cov_hi", 64'(co_valid), 64'd1);
      idle(); step();
      check("bypass_cov_lo", 64'(co_valid), 64'd0);

      // Reset in the cycle after issue discards the op
      idle(); set_op(2'd1, 2'd3, 1'b1, 1'b0, 64'd1, 64'd1); step();
      idle(); reset = 1'b1; step();
      idle();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_cov", 64'(co_valid), 64'd0);
      for (int i = 0; i < NREGS; i++) begin
         idle(); set_store(2'(i)); step();
         check("rst_tile", co, 64'd0);
      end

      // Randomized traffic
      for (int cyc = 0; cyc < 800; cyc++) begin
         idle();
         reset = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 9) < 6)
            set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), rand_word(), rand_word());
         if ($urandom_range(0, 9) < 2) set_load(2'($urandom_range(0, 3)), rand_word());
         if ($urandom_range(0, 9) < 4) set_store(2'($urandom_range(0, 3)));
         step();
      end
      idle();
      repeat (MS) step();
      for (int i = 0; i < NREGS; i++) begin
         idle(); set_store(2'(i)); step();
      end
      idle(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
